// File: rtl/zone_arb_pkg.sv
// zone_arb_pkg
//   Shared definitions for the zone supply arbiter slice.
//   - arb_state_t : arbiter state (IDLE, GRANT, SETTLE)
//   - SLICE_W     : width of the per-grant slice counter and slice_left port
package zone_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        SETTLE = 2'd2
    } arb_state_t;

    localparam int unsigned SLICE_W = 8;

endpackage

// File: rtl/zone_supply_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Finds the first set request bit
//   searching upward from rr_ptr, wrapping around past the top zone.
//   Ports:
//     req    in  NUM_ZONES  request levels
//     rr_ptr in  IDW        search start index
//     found  out 1          at least one request is set
//     idx    out IDW        index of the winning zone (0 when !found)
module rr_pick
    import zone_arb_pkg::*;
#(
    parameter int unsigned NUM_ZONES = 4,
    parameter int unsigned IDW       = $clog2(NUM_ZONES)
) (
    input  logic [NUM_ZONES-1:0] req,
    input  logic [IDW-1:0]       rr_ptr,
    output logic                 found,
    output logic [IDW-1:0]       idx
);

    int unsigned w_pos;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        w_pos = 0;
        for (int unsigned i = 0; i < NUM_ZONES; i++) begin
            w_pos = (32'(rr_ptr) + i) % NUM_ZONES;
            if (!found && req[w_pos[IDW-1:0]]) begin
                found = 1'b1;
                idx   = w_pos[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/zone_supply_arbiter.sv
// zone_supply_arbiter
//   Time-sliced round-robin arbiter sharing one pump/main supply line among
//   irrigation zones. At most one zone is granted at a time, each grant is
//   capped at SLICE_TICKS seconds, a valve-closed settle gap separates
//   grants, and inhibit drops any grant.
//   Ports:
//     clk         in  1          system clock
//     rst_n       in  1          asynchronous active-low reset
//     tick        in  1          one-cycle pulse per second
//     inhibit     in  1          forces all grants off (rain, fault)
//     req         in  NUM_ZONES  per-zone request level
//     grant       out NUM_ZONES  one-hot valve enable, registered
//     grant_valid out 1          OR of grant
//     grant_id    out IDW        granted zone index, holds last value
//     slice_left  out 8          remaining ticks of current grant, 0 if none
//     expired     out 1          one-cycle pulse on slice timeout
module zone_supply_arbiter
    import zone_arb_pkg::*;
#(
    parameter int unsigned NUM_ZONES   = 4,
    parameter int unsigned SLICE_TICKS = 30,
    parameter int unsigned SETTLE_CYC  = 8,
    parameter int unsigned IDW         = $clog2(NUM_ZONES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 inhibit,
    input  logic [NUM_ZONES-1:0] req,
    output logic [NUM_ZONES-1:0] grant,
    output logic                 grant_valid,
    output logic [IDW-1:0]       grant_id,
    output logic [SLICE_W-1:0]   slice_left,
    output logic                 expired
);

    arb_state_t           r_state;
    logic [NUM_ZONES-1:0] r_grant;
    logic [IDW-1:0]       r_grant_id;
    logic [SLICE_W-1:0]   r_slice;
    logic                 r_expired;
    logic [IDW-1:0]       r_rr_ptr;
    logic [7:0]           r_settle_cnt;

    arb_state_t           w_state_nxt;
    logic [NUM_ZONES-1:0] w_grant_nxt;
    logic [IDW-1:0]       w_grant_id_nxt;
    logic [SLICE_W-1:0]   w_slice_nxt;
    logic                 w_expired_nxt;
    logic [IDW-1:0]       w_rr_ptr_nxt;
    logic [7:0]           w_settle_cnt_nxt;

    logic                 w_found;
    logic [IDW-1:0]       w_pick_idx;
    logic                 w_arb_ok;
    logic [NUM_ZONES-1:0] w_pick_onehot;
    logic [IDW-1:0]       w_pick_ptr_nxt;
    logic                 w_release;

    rr_pick #(
        .NUM_ZONES (NUM_ZONES),
        .IDW       (IDW)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .found  (w_found),
        .idx    (w_pick_idx)
    );

    assign w_arb_ok  = !inhibit && w_found;
    assign w_release = !req[r_grant_id];

    always_comb begin
        w_pick_onehot             = '0;
        w_pick_onehot[w_pick_idx] = 1'b1;
        if (w_pick_idx == IDW'(NUM_ZONES - 1)) begin
            w_pick_ptr_nxt = '0;
        end else begin
            w_pick_ptr_nxt = w_pick_idx + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_grant_id_nxt   = r_grant_id;
        w_slice_nxt      = r_slice;
        w_expired_nxt    = 1'b0;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_settle_cnt_nxt = r_settle_cnt;

        case (r_state)
            IDLE: begin
                if (w_arb_ok) begin
                    w_state_nxt    = GRANT;
                    w_grant_nxt    = w_pick_onehot;
                    w_grant_id_nxt = w_pick_idx;
                    w_slice_nxt    = SLICE_W'(SLICE_TICKS);
                    w_rr_ptr_nxt   = w_pick_ptr_nxt;
                end
            end

            GRANT: begin
                // inhibit and release outrank expiry, so a tick landing on
                // slice_left==1 in the same cycle does not pulse expired.
                if (inhibit || w_release) begin
                    w_state_nxt      = SETTLE;
                    w_grant_nxt      = '0;
                    w_slice_nxt      = '0;
                    w_settle_cnt_nxt = '0;
                end else if (tick) begin
                    if (r_slice == SLICE_W'(1)) begin
                        w_state_nxt      = SETTLE;
                        w_grant_nxt      = '0;
                        w_slice_nxt      = '0;
                        w_settle_cnt_nxt = '0;
                        w_expired_nxt    = 1'b1;
                    end else begin
                        w_slice_nxt = r_slice - 1'b1;
                    end
                end
            end

            SETTLE: begin
                // The counter starts at 0 on the closing edge; arbitration
                // happens on the edge after it reaches SETTLE_CYC, which puts
                // the next grant SETTLE_CYC+1 cycles after the previous fell.
                if (r_settle_cnt == 8'(SETTLE_CYC)) begin
                    w_settle_cnt_nxt = '0;
                    if (w_arb_ok) begin
                        w_state_nxt    = GRANT;
                        w_grant_nxt    = w_pick_onehot;
                        w_grant_id_nxt = w_pick_idx;
                        w_slice_nxt    = SLICE_W'(SLICE_TICKS);
                        w_rr_ptr_nxt   = w_pick_ptr_nxt;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_settle_cnt_nxt = r_settle_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_slice_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_grant_id   <= '0;
            r_slice      <= '0;
            r_expired    <= 1'b0;
            r_rr_ptr     <= '0;
            r_settle_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_grant_id   <= w_grant_id_nxt;
            r_slice      <= w_slice_nxt;
            r_expired    <= w_expired_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = |r_grant;
    assign grant_id    = r_grant_id;
    assign slice_left  = r_slice;
    assign expired     = r_expired;

endmodule

// File: tb/tb_zone_supply_arbiter.sv
// tb_zone_supply_arbiter
//   Directed-vector bench for zone_supply_arbiter with a cycle-level
//   reference model (owner / remaining slice / closed-valve gap / pointer)
//   and hand-computed expectations at key points.
module tb_zone_supply_arbiter;

    localparam int N   = 4;
    localparam int SL  = 30;
    localparam int SC  = 8;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           tick = 1'b0;
    logic           inhibit = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic [7:0]     slice_left;
    logic           expired;

    int n_checks = 0;
    int n_err    = 0;
    int tick_per = 0;
    int tcnt     = 0;
    bit tick_once = 1'b0;
    int n_exp    = 0;

    // reference model state
    int m_owner = -1;
    int m_last  = 0;
    int m_left  = 0;
    int m_gap   = 0;
    int m_ptr   = 0;
    bit m_exp   = 1'b0;

    zone_supply_arbiter #(
        .NUM_ZONES   (N),
        .SLICE_TICKS (SL),
        .SETTLE_CYC  (SC),
        .IDW         (IDW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .inhibit     (inhibit),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .slice_left  (slice_left),
        .expired     (expired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // tick generator: periodic or one-shot, driven away from the active edge
    initial forever begin
        @(negedge clk);
        tick = ((tick_per != 0) && ((tcnt % tick_per) == 0)) || tick_once;
        tick_once = 1'b0;
        tcnt++;
    end

    // reference model: closing a grant starts a gap of SC+1 edges; the last
    // edge of the gap (or any edge with no owner and no gap) arbitrates.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_owner = -1; m_last = 0; m_left = 0; m_gap = 0; m_ptr = 0; m_exp = 1'b0;
        end else begin
            m_exp = 1'b0;
            if (m_owner >= 0) begin
                if (inhibit || !req[m_owner]) begin
                    m_owner = -1; m_left = 0; m_gap = SC + 1;
                end else if (tick) begin
                    if (m_left == 1) begin
                        m_owner = -1; m_left = 0; m_gap = SC + 1; m_exp = 1'b1;
                    end else begin
                        m_left--;
                    end
                end
            end else if (m_gap > 1) begin
                m_gap--;
            end else begin
                m_gap = 0;
                if (!inhibit) begin
                    for (int i = 0; i < N; i++) begin
                        int k;
                        k = (m_ptr + i) % N;
                        if (m_owner < 0 && req[k]) begin
                            m_owner = k; m_last = k; m_left = SL; m_ptr = (k + 1) % N;
                        end
                    end
                end
            end
        end
    end

    // per-cycle comparison against the model
    initial forever begin
        logic [N-1:0] mg;
        @(posedge clk);
        #1;
        mg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        chk("grant", 32'(grant), 32'(mg));
        chk("grant_valid", 32'(grant_valid), 32'(mg != '0));
        chk("grant_id", 32'(grant_id), 32'(m_last));
        chk("slice_left", 32'(slice_left), 32'(m_left));
        chk("expired", 32'(expired), 32'(m_exp));
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (expired === 1'b1) n_exp++;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_grant(input int maxc, output int c);
        c = 0;
        while (grant == '0 && c < maxc) begin
            cyc(1);
            c++;
        end
        if (grant == '0) chk("wait_grant_timeout", 32'(grant), 32'hFFFF_FFFF);
    endtask

    task automatic wait_fall(input int maxc, output int c);
        c = 0;
        while (grant != '0 && c < maxc) begin
            cyc(1);
            c++;
        end
        if (grant != '0) chk("wait_fall_timeout", 32'(grant), 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int c;
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // reset state
        cyc(2);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_slice", 32'(slice_left), 32'h0);
        chk("rst_id", 32'(grant_id), 32'h0);
        rst_n = 1'b1;
        cyc(2);

        // single request, release
        req = 4'b0001;
        cyc(1);
        chk("single_grant", 32'(grant), 32'h1);
        chk("single_slice", 32'(slice_left), 32'd30);
        chk("single_valid", 32'(grant_valid), 32'h1);
        cyc(13);
        req = 4'b0000;
        cyc(1);
        chk("release_grant", 32'(grant), 32'h0);
        chk("release_expired", 32'(expired), 32'h0);
        cyc(12);

        // round robin with all zones requesting
        do_reset();
        n_exp = 0;
        tick_per = 3;
        req = 4'b1111;
        wait_grant(5, c);
        chk("rr_first_lat", 32'(c), 32'd1);
        chk("rr_order0", 32'(grant_id), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            wait_fall(200, c);
            wait_grant(20, c);
            chk("rr_gap", 32'(c), 32'd9);
            chk("rr_order", 32'(grant_id), 32'(k % 4));
        end
        chk("rr_expired_count", 32'(n_exp), 32'd4);
        req = 4'b0000;
        tick_per = 0;
        cyc(15);

        // sole requester expiry and re-grant
        req = 4'b0100;
        tick_per = 3;
        wait_grant(5, c);
        chk("sole_grant", 32'(grant), 32'h4);
        c = 0;
        while (expired !== 1'b1 && c < 200) begin
            cyc(1);
            c++;
        end
        chk("sole_expired", 32'(expired), 32'h1);
        chk("sole_fall", 32'(grant), 32'h0);
        wait_grant(20, c);
        chk("sole_regrant_gap", 32'(c), 32'd9);
        chk("sole_regrant", 32'(grant), 32'h4);
        req = 4'b0000;
        tick_per = 0;
        cyc(15);

        // inhibit coincident with final tick
        req = 4'b0010;
        wait_grant(5, c);
        chk("inh_grant", 32'(grant), 32'h2);
        for (int k = 0; k < 29; k++) begin
            tick_once = 1'b1;
            cyc(2);
        end
        chk("inh_slice1", 32'(slice_left), 32'd1);
        inhibit = 1'b1;
        tick_once = 1'b1;
        cyc(1);
        chk("inh_fall", 32'(grant), 32'h0);
        chk("inh_no_expired", 32'(expired), 32'h0);
        cyc(30);
        chk("inh_hold", 32'(grant), 32'h0);
        req = 4'b0000;
        inhibit = 1'b0;
        cyc(12);

        // release together with a new request
        req = 4'b0010;
        wait_grant(5, c);
        chk("rel_grant1", 32'(grant_id), 32'd1);
        req = 4'b1000;
        wait_fall(5, c);
        chk("rel_fall_lat", 32'(c), 32'd1);
        wait_grant(20, c);
        chk("rel_gap", 32'(c), 32'd9);
        chk("rel_grant3", 32'(grant), 32'h8);
        req = 4'b0011;
        wait_fall(5, c);
        wait_grant(20, c);
        chk("rel_ptr_wrap", 32'(grant_id), 32'd0);
        req = 4'b0010;
        wait_fall(5, c);
        wait_grant(20, c);
        chk("pre_rst_grant", 32'(grant), 32'h2);

        // reset mid-grant
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 32'h0);
        chk("arst_valid", 32'(grant_valid), 32'h0);
        chk("arst_slice", 32'(slice_left), 32'h0);
        chk("arst_id", 32'(grant_id), 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("post_rst_grant", 32'(grant), 32'h2);
        chk("post_rst_slice", 32'(slice_left), 32'd30);
        req = 4'b0000;
        cyc(12);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
